// File: rtl/step_pkg.sv
// Shared types and constants for the step/direction decoder.
package step_pkg;

    localparam int PERIOD_W         = 17;
    localparam int POS_W            = 32;
    localparam int DEF_MIN_PERIOD   = 1000;
    localparam int DEF_STALL_CYCLES = 10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (&v) ? v : v + PERIOD_W'(1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous control input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_decoder.sv
// Step/dir decoder: measures step period, detects overspeed and stall, tracks position.
// Define STEP_DECODER_POS_EN to build the signed position counter; otherwise position reads 0.
module step_decoder
    import step_pkg::*;
#(
    parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                drv_step,
    input  logic                drv_dir,
    input  logic                drv_en_SM,
    input  logic                ovs_clr,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic [POS_W-1:0]    position,
    output logic [1:0]          state,
    output logic                overspeed,
    output logic                stall
);

    localparam logic [PERIOD_W-1:0] MIN_LIM   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] STALL_LIM = PERIOD_W'(STALL_CYCLES);

    logic                step_s, dir_s, en_s;
    logic                step_q;
    logic                step_edge;
    logic [PERIOD_W-1:0] gap_q;
    state_t              state_q;

    sync2 u_sync_step (.clk(clk), .rst(rst), .d(drv_step),  .q(step_s));
    sync2 u_sync_dir  (.clk(clk), .rst(rst), .d(drv_dir),   .q(dir_s));
    sync2 u_sync_en   (.clk(clk), .rst(rst), .d(drv_en_SM), .q(en_s));

    assign step_edge = step_s & ~step_q;
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q       <= 1'b0;
            state_q      <= IDLE;
            gap_q        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overspeed    <= 1'b0;
            stall        <= 1'b0;
        end else begin
            step_q       <= step_s;
            period_valid <= 1'b0;
            // NOTE: the later overspeed set in RUN overrides this clear; the last
            // non-blocking assignment in the block wins, giving set priority.
            if (ovs_clr)
                overspeed <= 1'b0;

            if (!en_s) begin
                state_q <= IDLE;
                stall   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARMED;
                    ARMED: begin
                        if (step_edge) begin
                            state_q <= RUN;
                            gap_q   <= PERIOD_W'(1);
                        end
                    end
                    RUN: begin
                        // An edge landing on the stall limit still counts as a RUN edge.
                        if (step_edge) begin
                            period       <= gap_q;
                            period_valid <= 1'b1;
                            gap_q        <= PERIOD_W'(1);
                            if (gap_q < MIN_LIM)
                                overspeed <= 1'b1;
                        end else if (gap_q == STALL_LIM) begin
                            state_q <= STALL;
                            stall   <= 1'b1;
                        end else begin
                            gap_q <= sat_inc(gap_q);
                        end
                    end
                    STALL: begin
                        if (step_edge) begin
                            state_q <= ARMED;
                            stall   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

`ifdef STEP_DECODER_POS_EN
    logic             step_accept;
    logic [POS_W-1:0] pos_q;

    assign step_accept = en_s & step_edge & (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pos_q <= '0;
        else if (step_accept)
            pos_q <= pos_q + (dir_s ? POS_W'(1) : {POS_W{1'b1}});
    end

    assign position = pos_q;
`else
    logic unused_dir;

    assign unused_dir = dir_s;
    assign position   = '0;
`endif

endmodule

// File: tb/tb_step_decoder.sv
// Directed bench for step_decoder with a scoreboard of per-edge expected outputs.
module tb_step_decoder;

    localparam int         MIN_P      = 1000;
    localparam int         STALL_C    = 10000;
    localparam int         STALL_WAIT = STALL_C - 1 - (800 - 4);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_STALL    = 2'd3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        drv_step  = 1'b0;
    logic        drv_dir   = 1'b0;
    logic        drv_en_SM = 1'b0;
    logic        ovs_clr   = 1'b0;
    logic [16:0] period;
    logic        period_valid;
    logic [31:0] position;
    logic [1:0]  state;
    logic        overspeed;
    logic        stall;

    step_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .drv_step    (drv_step),
        .drv_dir     (drv_dir),
        .drv_en_SM   (drv_en_SM),
        .ovs_clr     (ovs_clr),
        .period      (period),
        .period_valid(period_valid),
        .position    (position),
        .state       (state),
        .overspeed   (overspeed),
        .stall       (stall)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [16:0] per;
        logic [31:0] pos;
        logic [1:0]  st;
        logic        ovs;
        logic        stl;
    } exp_t;

    exp_t sb[$];

    int          n_vec    = 0;
    int          n_miss   = 0;
    int          pv_seen  = 0;
    int          pv_exp   = 0;
    int          prev_gap = 0;
    logic [1:0]  m_state  = S_IDLE;
    logic [16:0] m_period = '0;
    logic [31:0] m_pos    = '0;
    logic        m_ovs    = 1'b0;
    logic        m_en     = 1'b0;

    always @(negedge clk) begin
        if (period_valid === 1'b1)
            pv_seen++;
    end

    initial begin
        #(2_000_000);
        $display("FAIL timeout: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pos_after(input logic [31:0] p, input logic d);
`ifdef STEP_DECODER_POS_EN
        return d ? p + 32'd1 : p - 32'd1;
`else
        return d ? p : p;
`endif
    endfunction

    task automatic check_outputs(input string name, input exp_t e);
        check({name, ".pv"},     32'(period_valid), 32'(e.pv));
        check({name, ".period"}, 32'(period),       32'(e.per));
        check({name, ".pos"},    position,          e.pos);
        check({name, ".state"},  32'(state),        32'(e.st));
        check({name, ".ovs"},    32'(overspeed),    32'(e.ovs));
        check({name, ".stall"},  32'(stall),        32'(e.stl));
    endtask

    // Raw step rise at a negedge; outputs are sampled just after the third posedge.
    // The next call's rise lands exactly 'gap' cycles after this one.
    task automatic do_step(input string name, input logic d, input int gap,
                           input logic clr, input logic en_drop);
        exp_t e;
        logic set;
        logic pv;
        @(negedge clk);
        drv_dir  = d;
        drv_step = 1'b1;
        if (en_drop) begin
            drv_en_SM = 1'b0;
            m_en      = 1'b0;
        end
        set = 1'b0;
        pv  = 1'b0;
        if (!m_en) begin
            m_state = S_IDLE;
        end else begin
            case (m_state)
                S_ARMED: begin
                    m_state = S_RUN;
                    m_pos   = pos_after(m_pos, d);
                end
                S_RUN: begin
                    m_period = 17'(prev_gap);
                    pv       = 1'b1;
                    pv_exp++;
                    set      = (prev_gap < MIN_P);
                    m_pos    = pos_after(m_pos, d);
                end
                S_STALL: begin
                    m_state = S_ARMED;
                    m_pos   = pos_after(m_pos, d);
                end
                default: ;
            endcase
        end
        if (set)
            m_ovs = 1'b1;
        else if (clr)
            m_ovs = 1'b0;
        e.pv  = pv;
        e.per = m_period;
        e.pos = m_pos;
        e.st  = m_state;
        e.ovs = m_ovs;
        e.stl = (m_state == S_STALL);
        sb.push_back(e);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ovs_clr = clr;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(name, e);
        @(negedge clk);
        ovs_clr  = 1'b0;
        drv_step = 1'b0;
        repeat (gap - 4) @(negedge clk);
        prev_gap = gap;
    endtask

    task automatic clr_pulse(input string name);
        ovs_clr = 1'b1;
        m_ovs   = 1'b0;
        @(posedge clk);
        #1;
        check(name, 32'(overspeed), 32'(m_ovs));
        ovs_clr = 1'b0;
    endtask

    task automatic enable_and_arm(input string name);
        @(negedge clk);
        drv_en_SM = 1'b1;
        m_en      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_state = S_ARMED;
        check(name, 32'(state), 32'(m_state));
    endtask

    initial begin
        exp_t zero;
        zero = '{pv: 1'b0, per: '0, pos: '0, st: S_IDLE, ovs: 1'b0, stl: 1'b0};

        // Power-on reset
        #5 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", zero);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_enable", 32'(state), 32'(S_IDLE));

        enable_and_arm("armed");

        // Nominal 1000-cycle stepping, forward
        for (int i = 0; i < 5; i++)
            do_step("run1000", 1'b1, 1000, 1'b0, 1'b0);
        check("pv_count_5_edges", 32'(pv_seen), 32'd4);
`ifdef STEP_DECODER_POS_EN
        check("pos_after_5", position, 32'd5);
`else
        check("pos_after_5", position, 32'd0);
`endif

        // Overspeed set, clear, and set-wins-over-clear
        do_step("ovs_a", 1'b1, 800, 1'b0, 1'b0);
        do_step("ovs_b", 1'b1, 800, 1'b0, 1'b0);
        clr_pulse("ovs_clear");
        do_step("ovs_c", 1'b1, 800, 1'b0, 1'b0);
        do_step("ovs_coincident_clr", 1'b1, 10000, 1'b1, 1'b0);
        clr_pulse("ovs_clear2");

        // Edge exactly at the stall limit is a RUN edge with period = STALL_CYCLES
        do_step("edge_at_stall_limit", 1'b1, 800, 1'b0, 1'b0);
        check("period_eq_stall", 32'(period), 32'(STALL_C));

        // No edges: RUN one cycle before the limit, STALL on it
        repeat (STALL_WAIT) @(posedge clk);
        #1;
        check("pre_stall_state", 32'(state), 32'(S_RUN));
        check("pre_stall_flag", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        m_state = S_STALL;
        check("stall_state", 32'(state), 32'(m_state));
        check("stall_flag", 32'(stall), 32'd1);

        do_step("stall_exit", 1'b1, 1000, 1'b0, 1'b0);
        check("pv_count_stall_exit", 32'(pv_seen), 32'(pv_exp));
        do_step("rearm_run", 1'b1, 1000, 1'b0, 1'b0);

        // Disable coincident with an edge, then an edge while idle
        do_step("en_drop_edge", 1'b1, 1000, 1'b0, 1'b1);
        do_step("idle_edge", 1'b0, 1000, 1'b0, 1'b0);
        enable_and_arm("rearmed");
        do_step("pre_rst_a", 1'b1, 1000, 1'b0, 1'b0);
        do_step("pre_rst_b", 1'b1, 1000, 1'b0, 1'b0);

        // Reset mid-RUN clears everything immediately
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_outputs("mid_run_reset", zero);
        m_state  = S_IDLE;
        m_period = '0;
        m_pos    = '0;
        m_ovs    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_state = S_ARMED;
        check("post_reset_armed", 32'(state), 32'(m_state));

        // Three forward then five reverse steps
        for (int i = 0; i < 3; i++)
            do_step("dir_fwd", 1'b1, 1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            do_step("dir_rev", 1'b0, 1000, 1'b0, 1'b0);
`ifdef STEP_DECODER_POS_EN
        check("pos_net", position, 32'hFFFF_FFFE);
`else
        check("pos_net", position, 32'd0);
`endif
        check("pv_count_final", 32'(pv_seen), 32'(pv_exp));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
